ofmap_packetizer: RTL and testbench

- Transmit-side counterpart of the memory interface's output-packet receiver. Sits in each PE, between the spike/membrane unit and the NOC injection port.
- Buffers output spikes as (row, col) coordinates and formats each one as a 64-bit NOC output packet addressed to the memory interface.
- After the last spike of a timestep has left the block, it emits exactly one DONE packet.

---
 rtl/noc_pkg.sv | 40 ++++
 rtl/ofmap_packetizer_if.sv | 35 +++
 rtl/sync_fifo.sv | 47 ++++
 rtl/ofmap_packetizer.sv | 133 +++++++++++++
 tb/tb_ofmap_packetizer.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : noc_pkg
// Purpose  : NOC packet types, addresses and packet builder shared by PE blocks
// Revision : 1.0
// ============================================================================
package noc_pkg;

  localparam logic [1:0] INPUT_T  = 2'b00;
  localparam logic [1:0] KERNEL_T = 2'b01;
  localparam logic [1:0] OUTPUT_T = 2'b11;

  localparam logic [9:0] DONE_CODE = 10'h3FF;

  localparam logic [3:0] PE_ADDR    = 4'b0001;
  localparam logic [3:0] MEMIF_ADDR = 4'b0000;

  typedef struct packed {
    logic [3:0]  dst;
    logic [3:0]  src;
    logic [1:0]  ptype;
    logic [43:0] pad;
    logic [9:0]  payload;
  } noc_packet_t;

  function automatic noc_packet_t make_pkt(input logic [3:0] dst,
                                           input logic [3:0] src,
                                           input logic [1:0] ptype,
                                           input logic [9:0] payload);
    noc_packet_t p;
    p.dst     = dst;
    p.src     = src;
    p.ptype   = ptype;
    p.pad     = '0;
    p.payload = payload;
    return p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ofmap_packetizer_if.sv
`default_nettype none
// ============================================================================
// Module   : ofmap_packetizer_if
// Purpose  : Spike input, timestep close, NOC output and status signals
// Revision : 1.0
// ============================================================================
interface ofmap_packetizer_if;

  logic        spike_valid;
  logic        spike_ready;
  logic [4:0]  spike_row;
  logic [4:0]  spike_col;
  logic        ts_done;
  logic        ts_done_ready;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [63:0] pkt_data;
  logic [7:0]  timestep;
  logic [9:0]  spike_count;
  logic        range_err;

  modport master (
    output spike_valid, spike_row, spike_col, ts_done, pkt_ready,
    input  spike_ready, ts_done_ready, pkt_valid, pkt_data,
           timestep, spike_count, range_err
  );

  modport slave (
    input  spike_valid, spike_row, spike_col, ts_done, pkt_ready,
    output spike_ready, ts_done_ready, pkt_valid, pkt_data,
           timestep, spike_count, range_err
  );

endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock FIFO with show-ahead read data
// Revision : 1.0
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             wr_en_i,
  input  wire logic [WIDTH-1:0] wr_data_i,
  input  wire logic             rd_en_i,
  output logic      [WIDTH-1:0] rd_data_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en_i && !full_o)  wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en_i && !empty_o) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i && !full_o) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule
`default_nettype wire

// File: rtl/ofmap_packetizer.sv
`default_nettype none
// ============================================================================
// Module   : ofmap_packetizer
// Purpose  : Queues output spikes and emits NOC output packets plus one DONE
//            packet per timestep
// Revision : 1.0
// ============================================================================
module ofmap_packetizer
  import noc_pkg::*;
#(
  parameter logic [3:0] SRC_ADDR   = PE_ADDR,
  parameter logic [3:0] DST_ADDR   = MEMIF_ADDR,
  parameter int         FIFO_DEPTH = 8,
  parameter int         OFMAP_ROWS = 21,
  parameter int         OFMAP_COLS = 21
) (
  input wire logic           clk,
  input wire logic           reset,
  ofmap_packetizer_if.slave  bus
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] STREAM    = 2'd1;
  localparam logic [1:0] SEND_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        pkt_valid_q, pkt_valid_d;
  logic [63:0] pkt_data_q, pkt_data_d;
  logic        done_pending_q, done_pending_d;
  logic [7:0]  timestep_q, timestep_d;
  logic [9:0]  spike_count_q, spike_count_d;
  logic        range_err_q, range_err_d;

  logic        fifo_full, fifo_empty, fifo_wr, fifo_rd;
  logic [9:0]  fifo_head;
  logic        in_range, spike_acc, ts_take, out_free;

  assign in_range = ({27'd0, bus.spike_row} < 32'(OFMAP_ROWS)) &&
                    ({27'd0, bus.spike_col} < 32'(OFMAP_COLS));

  assign bus.spike_ready   = !fifo_full && !done_pending_q && !reset;
  assign bus.ts_done_ready = !done_pending_q && !reset;

  assign spike_acc = bus.spike_valid && bus.spike_ready;
  assign fifo_wr   = spike_acc && in_range;
  assign ts_take   = bus.ts_done && bus.ts_done_ready;
  assign out_free  = !pkt_valid_q || bus.pkt_ready;

  sync_fifo #(
    .WIDTH (10),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (fifo_wr),
    .wr_data_i ({bus.spike_row, bus.spike_col}),
    .rd_en_i   (fifo_rd),
    .rd_data_o (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  always_comb begin
    state_d        = state_q;
    pkt_valid_d    = pkt_valid_q;
    pkt_data_d     = pkt_data_q;
    done_pending_d = done_pending_q;
    timestep_d     = timestep_q;
    spike_count_d  = spike_count_q;
    range_err_d    = range_err_q;
    fifo_rd        = 1'b0;

    if (spike_acc && !in_range)                 range_err_d   = 1'b1;
    if (fifo_wr && spike_count_q != 10'h3FF)    spike_count_d = spike_count_q + 10'd1;
    if (ts_take)                                done_pending_d = 1'b1;
    if (pkt_valid_q && bus.pkt_ready)           pkt_valid_d   = 1'b0;

    case (state_q)
      IDLE, STREAM: begin
        // DONE is only built once every queued spike has been handed off.
        if (done_pending_q && fifo_empty && out_free) begin
          pkt_valid_d = 1'b1;
          pkt_data_d  = make_pkt(DST_ADDR, SRC_ADDR, OUTPUT_T, DONE_CODE);
          state_d     = SEND_DONE;
        end else begin
          if (!fifo_empty && out_free) begin
            pkt_valid_d = 1'b1;
            pkt_data_d  = make_pkt(DST_ADDR, SRC_ADDR, OUTPUT_T, fifo_head);
            fifo_rd     = 1'b1;
          end
          state_d = fifo_empty ? IDLE : STREAM;
        end
      end
      SEND_DONE: begin
        if (bus.pkt_ready) begin
          state_d        = IDLE;
          done_pending_d = 1'b0;
          timestep_d     = timestep_q + 8'd1;
          spike_count_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      pkt_valid_q    <= 1'b0;
      pkt_data_q     <= '0;
      done_pending_q <= 1'b0;
      timestep_q     <= '0;
      spike_count_q  <= '0;
      range_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      pkt_valid_q    <= pkt_valid_d;
      pkt_data_q     <= pkt_data_d;
      done_pending_q <= done_pending_d;
      timestep_q     <= timestep_d;
      spike_count_q  <= spike_count_d;
      range_err_q    <= range_err_d;
    end
  end

  assign bus.pkt_valid   = pkt_valid_q;
  assign bus.pkt_data    = pkt_data_q;
  assign bus.timestep    = timestep_q;
  assign bus.spike_count = spike_count_q;
  assign bus.range_err   = range_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ofmap_packetizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ofmap_packetizer
// Purpose  : Directed self-checking bench for ofmap_packetizer
// Revision : 1.0
// ============================================================================
module tb_ofmap_packetizer;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_miss;
  logic [63:0] rxq[$];

  localparam logic [63:0] DONE_PKT = 64'h01C0_0000_0000_03FF;

  ofmap_packetizer_if bus ();

  ofmap_packetizer u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs only change just after a rising edge, so the falling edge sees
  // exactly what the next rising edge will act on.
  always @(negedge clk) begin
    if (!reset && bus.pkt_valid && bus.pkt_ready) rxq.push_back(bus.pkt_data);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] exp_pkt(input logic [4:0] r, input logic [4:0] c);
    return {4'h0, 4'h1, 2'b11, 44'd0, r, c};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bound_fail(input string tag);
    n_vec++;
    n_miss++;
    $display("FAIL %s: got timeout, want handshake", tag);
  endtask

  task automatic send_spike(input logic [4:0] r, input logic [4:0] c);
    int k;
    bus.spike_row   = r;
    bus.spike_col   = c;
    bus.spike_valid = 1'b1;
    k = 0;
    while (!bus.spike_ready && k < 60) begin
      tick();
      k++;
    end
    if (!bus.spike_ready) bound_fail("spike_wait");
    tick();
    bus.spike_valid = 1'b0;
  endtask

  task automatic pulse_ts();
    int k;
    bus.ts_done = 1'b1;
    k = 0;
    while (!bus.ts_done_ready && k < 60) begin
      tick();
      k++;
    end
    if (!bus.ts_done_ready) bound_fail("ts_wait");
    tick();
    bus.ts_done = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_miss = 0;
    reset = 1'b1;
    bus.spike_valid = 1'b0;
    bus.spike_row   = '0;
    bus.spike_col   = '0;
    bus.ts_done     = 1'b0;
    bus.pkt_ready   = 1'b0;
    tick(2);

    // Reset state
    check_eq("rst_pkt_valid",     64'(bus.pkt_valid), 64'd0);
    check_eq("rst_pkt_data",      bus.pkt_data, 64'd0);
    check_eq("rst_spike_ready",   64'(bus.spike_ready), 64'd0);
    check_eq("rst_ts_done_ready", 64'(bus.ts_done_ready), 64'd0);
    check_eq("rst_timestep",      64'(bus.timestep), 64'd0);
    check_eq("rst_spike_count",   64'(bus.spike_count), 64'd0);
    check_eq("rst_range_err",     64'(bus.range_err), 64'd0);

    reset = 1'b0;
    bus.pkt_ready = 1'b1;
    tick();

    // Basic spike and latency
    bus.spike_row = 5'd3; bus.spike_col = 5'd7; bus.spike_valid = 1'b1;
    check_eq("basic_ready", 64'(bus.spike_ready), 64'd1);
    tick();
    bus.spike_valid = 1'b0;
    check_eq("basic_valid_n",  64'(bus.pkt_valid), 64'd0);
    check_eq("basic_count",    64'(bus.spike_count), 64'd1);
    tick();
    check_eq("basic_valid_n1", 64'(bus.pkt_valid), 64'd1);
    check_eq("basic_data",     bus.pkt_data, 64'h01C0_0000_0000_0067);
    tick(3);
    check_eq("basic_nrx", 64'(rxq.size()), 64'd1);
    rxq.delete();

    // DONE ordering behind stalled output
    bus.pkt_ready = 1'b0;
    send_spike(5'd10, 5'd1);
    send_spike(5'd10, 5'd2);
    send_spike(5'd10, 5'd3);
    pulse_ts();
    tick(5);
    check_eq("ord_count_pre", 64'(bus.spike_count), 64'd4);
    check_eq("ord_ts_ready",  64'(bus.ts_done_ready), 64'd0);
    bus.pkt_ready = 1'b1;
    tick(10);
    check_eq("ord_nrx", 64'(rxq.size()), 64'd4);
    if (rxq.size() == 4) begin
      check_eq("ord_p0",   rxq[0], 64'h01C0_0000_0000_0141);
      check_eq("ord_p1",   rxq[1], 64'h01C0_0000_0000_0142);
      check_eq("ord_p2",   rxq[2], 64'h01C0_0000_0000_0143);
      check_eq("ord_done", rxq[3], DONE_PKT);
    end
    check_eq("ord_timestep", 64'(bus.timestep), 64'd1);
    check_eq("ord_count",    64'(bus.spike_count), 64'd0);
    rxq.delete();

    // Back-pressure: output register plus 8 FIFO entries
    bus.pkt_ready = 1'b0;
    for (int i = 0; i < 9; i++) send_spike(5'(i), 5'(i));
    bus.spike_row = 5'd9; bus.spike_col = 5'd9; bus.spike_valid = 1'b1;
    tick(3);
    check_eq("bp_ready", 64'(bus.spike_ready), 64'd0);
    check_eq("bp_hold",  bus.pkt_data, 64'h01C0_0000_0000_0000);
    bus.spike_valid = 1'b0;
    bus.pkt_ready = 1'b1;
    tick(15);
    check_eq("bp_nrx", 64'(rxq.size()), 64'd9);
    if (rxq.size() == 9)
      for (int i = 0; i < 9; i++) check_eq($sformatf("bp_p%0d", i), rxq[i], exp_pkt(5'(i), 5'(i)));
    check_eq("bp_count", 64'(bus.spike_count), 64'd9);
    rxq.delete();
    pulse_ts();
    tick(6);
    check_eq("bp_done_nrx", 64'(rxq.size()), 64'd1);
    check_eq("bp_timestep", 64'(bus.timestep), 64'd2);
    rxq.delete();

    // Empty timestep
    pulse_ts();
    tick(6);
    check_eq("empty_nrx", 64'(rxq.size()), 64'd1);
    if (rxq.size() == 1) check_eq("empty_done", rxq[0], DONE_PKT);
    check_eq("empty_timestep", 64'(bus.timestep), 64'd3);
    rxq.delete();

    // Spike and ts_done together, then a spike that must wait for DONE
    bus.spike_row = 5'd20; bus.spike_col = 5'd20;
    bus.spike_valid = 1'b1; bus.ts_done = 1'b1;
    tick();
    bus.ts_done = 1'b0;
    bus.spike_row = 5'd5; bus.spike_col = 5'd5;
    check_eq("sim_stall", 64'(bus.spike_ready), 64'd0);
    send_spike(5'd5, 5'd5);
    tick(8);
    check_eq("sim_nrx", 64'(rxq.size()), 64'd3);
    if (rxq.size() == 3) begin
      check_eq("sim_p0",   rxq[0], 64'h01C0_0000_0000_0294);
      check_eq("sim_done", rxq[1], DONE_PKT);
      check_eq("sim_p2",   rxq[2], 64'h01C0_0000_0000_00A5);
    end
    check_eq("sim_timestep", 64'(bus.timestep), 64'd4);
    check_eq("sim_count",    64'(bus.spike_count), 64'd1);
    rxq.delete();

    // Out-of-range coordinates are swallowed
    send_spike(5'd21, 5'd0);
    send_spike(5'd0, 5'd21);
    tick(4);
    check_eq("rng_err",   64'(bus.range_err), 64'd1);
    check_eq("rng_nrx",   64'(rxq.size()), 64'd0);
    check_eq("rng_count", 64'(bus.spike_count), 64'd1);

    // Reset while a packet is held
    bus.pkt_ready = 1'b0;
    send_spike(5'd1, 5'd1);
    tick(2);
    check_eq("mr_valid_pre", 64'(bus.pkt_valid), 64'd1);
    reset = 1'b1;
    tick();
    check_eq("mr_valid",    64'(bus.pkt_valid), 64'd0);
    check_eq("mr_data",     bus.pkt_data, 64'd0);
    check_eq("mr_range",    64'(bus.range_err), 64'd0);
    check_eq("mr_count",    64'(bus.spike_count), 64'd0);
    check_eq("mr_timestep", 64'(bus.timestep), 64'd0);
    reset = 1'b0;
    bus.pkt_ready = 1'b1;
    tick(5);
    check_eq("mr_nrx",   64'(rxq.size()), 64'd0);
    check_eq("mr_valid_post", 64'(bus.pkt_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
